// File: rtl/rv32_multicycle_ctrl_if.sv
// Shared instruction/data memory request/ack handshake seen by the main control FSM.
// The controller drives the request side; the memory answers with a one-cycle ack.
interface rv32_multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic IorD;
    logic mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output IorD,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  IorD,
        output mem_ack
    );
endinterface

// File: rtl/rv32_multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: fetch, decode, execute, memory, write-back.
// Drives ALU function/operand selects and resolves branches from the ALU Zero/Sign flags.
module rv32_multicycle_ctrl #(
    parameter int unsigned CONTROL_WIDTH = 3
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [6:0]               opcode,
    input  logic [2:0]               funct3,
    input  logic                     funct7_5,
    input  logic                     Zero_Flag,
    input  logic                     Sign_Flag,
    rv32_multicycle_ctrl_if.master   mem,
    output logic                     IR_write,
    output logic                     PC_write,
    output logic                     PC_src,
    output logic [1:0]               ALU_srcA,
    output logic [1:0]               ALU_srcB,
    output logic [1:0]               ImmSrc,
    output logic [CONTROL_WIDTH-1:0] ALU_FUN,
    output logic                     RegWrite,
    output logic                     ResultSrc,
    output logic                     illegal,
    output logic [2:0]               state_dbg
);

    localparam logic [2:0] StFetch  = 3'd0;
    localparam logic [2:0] StDecode = 3'd1;
    localparam logic [2:0] StExec   = 3'd2;
    localparam logic [2:0] StMem    = 3'd3;
    localparam logic [2:0] StWb     = 3'd4;
    localparam logic [2:0] StTrap   = 3'd5;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    logic [2:0] state_q, state_d;
    logic       illegal_q, illegal_d;

    logic is_r, is_imm, is_load, is_store, is_branch, is_jal;
    logic alu_f3_ok, is_shift, legal, taken;
    logic req_raw, ack;

    assign is_r      = (opcode == OpR);
    assign is_imm    = (opcode == OpImm);
    assign is_load   = (opcode == OpLoad);
    assign is_store  = (opcode == OpStore);
    assign is_branch = (opcode == OpBranch);
    assign is_jal    = (opcode == OpJal);

    // funct3 010/011 (slt/sltu) have no ALU encoding; sra/srai are rejected via funct7_5
    assign alu_f3_ok = (funct3 != 3'b010) && (funct3 != 3'b011);
    assign is_shift  = (funct3 == 3'b001) || (funct3 == 3'b101);

    assign legal = (is_r && alu_f3_ok && (!funct7_5 || funct3 == 3'b000))
                || (is_imm && alu_f3_ok && !(is_shift && funct7_5))
                || ((is_load || is_store) && funct3 == 3'b010)
                || (is_branch && funct3[1] == 1'b0)
                || is_jal;

    // funct3[2] picks the flag (Zero vs Sign), funct3[0] inverts it
    assign taken = (funct3[2] ? Sign_Flag : Zero_Flag) ^ funct3[0];

    // Request and ack are gated by reset so an in-flight access is dropped at once
    assign req_raw     = (state_q == StFetch) || (state_q == StMem);
    assign mem.mem_req = req_raw & RST;
    assign mem.mem_we  = (state_q == StMem) & is_store & RST;
    assign mem.IorD    = (state_q == StMem);
    assign ack         = mem.mem_ack & req_raw & RST;

    assign illegal   = illegal_q;
    assign state_dbg = state_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        IR_write  = 1'b0;
        PC_write  = 1'b0;
        PC_src    = 1'b0;
        ALU_srcA  = 2'b00;
        ALU_srcB  = 2'b00;
        ImmSrc    = 2'b00;
        ALU_FUN   = '0;
        RegWrite  = 1'b0;
        ResultSrc = 1'b0;

        case (state_q)
            StFetch: begin
                ALU_srcB = 2'b10;
                if (ack) begin
                    IR_write = 1'b1;
                    PC_write = 1'b1;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                // Precompute branch/jal target into ALUOut from the old PC
                ALU_srcA = 2'b10;
                ALU_srcB = 2'b01;
                if (is_branch)   ImmSrc = 2'b10;
                else if (is_jal) ImmSrc = 2'b11;
                if (legal) begin
                    state_d = StExec;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = StTrap;
                end
            end
            StExec: begin
                state_d = StFetch;
                if (is_r) begin
                    ALU_srcA = 2'b01;
                    ALU_FUN  = (funct3 == 3'b000 && funct7_5) ? CONTROL_WIDTH'(3'b010)
                                                              : CONTROL_WIDTH'(funct3);
                    state_d  = StWb;
                end else if (is_imm) begin
                    ALU_srcA = 2'b01;
                    ALU_srcB = 2'b01;
                    ALU_FUN  = CONTROL_WIDTH'(funct3);
                    state_d  = StWb;
                end else if (is_load || is_store) begin
                    ALU_srcA = 2'b01;
                    ALU_srcB = 2'b01;
                    ImmSrc   = is_store ? 2'b01 : 2'b00;
                    state_d  = StMem;
                end else if (is_branch) begin
                    ALU_srcA = 2'b01;
                    ALU_FUN  = CONTROL_WIDTH'(3'b010);
                    PC_write = taken;
                    PC_src   = taken;
                end else if (is_jal) begin
                    // ALU forms the link value old PC + 4 while PC takes ALUOut
                    ALU_srcA = 2'b10;
                    ALU_srcB = 2'b10;
                    PC_write = 1'b1;
                    PC_src   = 1'b1;
                    state_d  = StWb;
                end
            end
            StMem: begin
                if (ack) state_d = is_load ? StWb : StFetch;
            end
            StWb: begin
                RegWrite  = 1'b1;
                ResultSrc = is_load;
                state_d   = StFetch;
            end
            StTrap: begin
                state_d = StTrap;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
// Directed bench for the multi-cycle control FSM: per-cycle state/output traces per instruction.
module tb_rv32_multicycle_ctrl;

    logic       CLK;
    logic       RST;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       Zero_Flag;
    logic       Sign_Flag;
    logic       IR_write, PC_write, PC_src, RegWrite, ResultSrc, illegal;
    logic [1:0] ALU_srcA, ALU_srcB, ImmSrc;
    logic [2:0] ALU_FUN, state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    rv32_multicycle_ctrl_if bus ();

    rv32_multicycle_ctrl #(.CONTROL_WIDTH(3)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7_5  (funct7_5),
        .Zero_Flag (Zero_Flag),
        .Sign_Flag (Sign_Flag),
        .mem       (bus),
        .IR_write  (IR_write),
        .PC_write  (PC_write),
        .PC_src    (PC_src),
        .ALU_srcA  (ALU_srcA),
        .ALU_srcB  (ALU_srcB),
        .ImmSrc    (ImmSrc),
        .ALU_FUN   (ALU_FUN),
        .RegWrite  (RegWrite),
        .ResultSrc (ResultSrc),
        .illegal   (illegal),
        .state_dbg (state_dbg)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RST = 1'b0; bus.mem_ack = 1'b0;
        opcode = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b0;
        Zero_Flag = 1'b0; Sign_Flag = 1'b0;
        tick; tick;
        RST = 1'b1;
        #1;
        n_cmp++; if (bus.mem_req !== 1'b1) begin n_err++;
            $display("FAIL rst_fetch_req got %b want 1", bus.mem_req); end
        tick;
        #2 RST = 1'b0;
        #1;
        n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++;
            $display("FAIL rst_async_req got %b want 0", bus.mem_req); end
        n_cmp++; if (state_dbg !== 3'd0) begin n_err++;
            $display("FAIL rst_async_state got %0d want 0", state_dbg); end
        n_cmp++; if (illegal !== 1'b0) begin n_err++;
            $display("FAIL rst_illegal got %b want 0", illegal); end
        bus.mem_ack = 1'b1;
        tick;
        n_cmp++; if (bus.mem_req !== 1'b0 || IR_write !== 1'b0) begin n_err++;
            $display("FAIL rst_held req=%b irw=%b want 0 0", bus.mem_req, IR_write); end
        RST = 1'b1;
        #1;
        n_cmp++; if (IR_write !== 1'b1 || PC_write !== 1'b1) begin n_err++;
            $display("FAIL rst_first_fetch irw=%b pcw=%b want 1 1", IR_write, PC_write); end
        tick;
        n_cmp++; if (state_dbg !== 3'd1) begin n_err++;
            $display("FAIL rst_to_decode got %0d want 1", state_dbg); end
        tick; tick; tick;
        n_cmp++; if (state_dbg !== 3'd0) begin n_err++;
            $display("FAIL rst_add_done got %0d want 0", state_dbg); end
    endtask

    task automatic test_r_type;
        logic [2:0] exp_st [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
        logic [2:0] exp_fun;
        for (int k = 0; k < 2; k++) begin
            opcode = 7'b0110011; funct3 = 3'b000; funct7_5 = (k == 1);
            exp_fun = (k == 1) ? 3'b010 : 3'b000;
            bus.mem_ack = 1'b1;
            for (int c = 0; c < 4; c++) begin
                #1;
                n_cmp++; if (state_dbg !== exp_st[c]) begin n_err++;
                    $display("FAIL r%0d_state c=%0d got %0d want %0d", k, c, state_dbg, exp_st[c]); end
                n_cmp++; if (RegWrite !== (exp_st[c] == 3'd4)) begin n_err++;
                    $display("FAIL r%0d_regwrite c=%0d got %b", k, c, RegWrite); end
                if (exp_st[c] == 3'd2) begin
                    n_cmp++; if (ALU_FUN !== exp_fun || ALU_srcA !== 2'b01 || ALU_srcB !== 2'b00)
                    begin n_err++;
                        $display("FAIL r%0d_exec fun=%b a=%b b=%b want %b 01 00",
                                 k, ALU_FUN, ALU_srcA, ALU_srcB, exp_fun); end
                end
                tick;
            end
            n_cmp++; if (state_dbg !== 3'd0) begin n_err++;
                $display("FAIL r%0d_latency got %0d want 0", k, state_dbg); end
        end
    endtask

    task automatic test_lw_wait;
        logic [2:0] exp_st [11] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2,
                                    3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
        logic exp_req;
        opcode = 7'b0000011; funct3 = 3'b010; funct7_5 = 1'b0;
        for (int c = 0; c < 11; c++) begin
            bus.mem_ack = (c == 3) || (c == 9);
            #1;
            exp_req = (exp_st[c] == 3'd0) || (exp_st[c] == 3'd3);
            n_cmp++; if (state_dbg !== exp_st[c]) begin n_err++;
                $display("FAIL lw_state c=%0d got %0d want %0d", c, state_dbg, exp_st[c]); end
            n_cmp++; if (bus.mem_req !== exp_req) begin n_err++;
                $display("FAIL lw_req c=%0d got %b want %b", c, bus.mem_req, exp_req); end
            n_cmp++; if (IR_write !== (c == 3)) begin n_err++;
                $display("FAIL lw_irwrite c=%0d got %b", c, IR_write); end
            if (exp_st[c] == 3'd3) begin
                n_cmp++; if (bus.IorD !== 1'b1 || bus.mem_we !== 1'b0) begin n_err++;
                    $display("FAIL lw_mem c=%0d iord=%b we=%b want 1 0", c, bus.IorD, bus.mem_we); end
            end
            if (exp_st[c] == 3'd4) begin
                n_cmp++; if (ResultSrc !== 1'b1 || RegWrite !== 1'b1) begin n_err++;
                    $display("FAIL lw_wb rs=%b rw=%b want 1 1", ResultSrc, RegWrite); end
            end
            tick;
        end
        bus.mem_ack = 1'b1;
        n_cmp++; if (state_dbg !== 3'd0) begin n_err++;
            $display("FAIL lw_latency got %0d want 0", state_dbg); end
    endtask

    task automatic test_branch;
        logic [2:0] f3  [4] = '{3'b000, 3'b000, 3'b100, 3'b100};
        logic       flg [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            opcode = 7'b1100011; funct3 = f3[k]; funct7_5 = 1'b0;
            // flags opposite to the EXEC value outside EXEC
            Zero_Flag = ~flg[k]; Sign_Flag = ~flg[k];
            bus.mem_ack = 1'b1;
            tick;
            n_cmp++; if (state_dbg !== 3'd1 || ImmSrc !== 2'b10) begin n_err++;
                $display("FAIL br%0d_decode st=%0d imm=%b want 1 10", k, state_dbg, ImmSrc); end
            tick;
            if (f3[k] == 3'b000) Zero_Flag = flg[k];
            else                 Sign_Flag = flg[k];
            #1;
            n_cmp++; if (state_dbg !== 3'd2 || ALU_FUN !== 3'b010) begin n_err++;
                $display("FAIL br%0d_exec st=%0d fun=%b want 2 010", k, state_dbg, ALU_FUN); end
            n_cmp++; if (PC_write !== flg[k] || PC_src !== flg[k]) begin n_err++;
                $display("FAIL br%0d_taken pcw=%b pcs=%b want %b", k, PC_write, PC_src, flg[k]); end
            tick;
            n_cmp++; if (state_dbg !== 3'd0) begin n_err++;
                $display("FAIL br%0d_next got %0d want 0", k, state_dbg); end
        end
    endtask

    task automatic test_store_jal;
        logic [2:0] exp_st [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
        opcode = 7'b0100011; funct3 = 3'b010; funct7_5 = 1'b0;
        bus.mem_ack = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_cmp++; if (state_dbg !== exp_st[c] || RegWrite !== 1'b0) begin n_err++;
                $display("FAIL sw_state c=%0d st=%0d rw=%b want %0d 0", c, state_dbg, RegWrite,
                         exp_st[c]); end
            if (exp_st[c] == 3'd2) begin
                n_cmp++; if (ImmSrc !== 2'b01) begin n_err++;
                    $display("FAIL sw_immsrc got %b want 01", ImmSrc); end
            end
            if (exp_st[c] == 3'd3) begin
                n_cmp++; if (bus.mem_we !== 1'b1 || bus.IorD !== 1'b1) begin n_err++;
                    $display("FAIL sw_mem we=%b iord=%b want 1 1", bus.mem_we, bus.IorD); end
            end
            tick;
        end
        n_cmp++; if (state_dbg !== 3'd0) begin n_err++;
            $display("FAIL sw_latency got %0d want 0", state_dbg); end
        opcode = 7'b1101111; funct3 = 3'b011; funct7_5 = 1'b1;
        tick;
        n_cmp++; if (ImmSrc !== 2'b11) begin n_err++;
            $display("FAIL jal_decode imm=%b want 11", ImmSrc); end
        tick;
        n_cmp++; if (state_dbg !== 3'd2 || PC_write !== 1'b1 || PC_src !== 1'b1 ||
                     ALU_srcA !== 2'b10 || ALU_srcB !== 2'b10) begin n_err++;
            $display("FAIL jal_exec st=%0d pcw=%b pcs=%b a=%b b=%b", state_dbg, PC_write, PC_src,
                     ALU_srcA, ALU_srcB); end
        tick;
        n_cmp++; if (state_dbg !== 3'd4 || RegWrite !== 1'b1 || ResultSrc !== 1'b0) begin n_err++;
            $display("FAIL jal_wb st=%0d rw=%b rs=%b want 4 1 0", state_dbg, RegWrite, ResultSrc); end
        tick;
    endtask

    task automatic test_illegal;
        logic [6:0] op [2] = '{7'b0010011, 7'b0110111};
        for (int k = 0; k < 2; k++) begin
            opcode = op[k]; funct3 = 3'b101; funct7_5 = 1'b1;
            bus.mem_ack = 1'b1;
            n_cmp++; if (state_dbg !== 3'd0) begin n_err++;
                $display("FAIL ill%0d_start got %0d want 0", k, state_dbg); end
            tick; tick;
            n_cmp++; if (state_dbg !== 3'd5 || illegal !== 1'b1) begin n_err++;
                $display("FAIL ill%0d_trap st=%0d ill=%b want 5 1", k, state_dbg, illegal); end
            for (int c = 0; c < 4; c++) begin
                n_cmp++; if (bus.mem_req !== 1'b0 || state_dbg !== 3'd5) begin n_err++;
                    $display("FAIL ill%0d_hold c=%0d req=%b st=%0d", k, c, bus.mem_req, state_dbg); end
                tick;
            end
            RST = 1'b0;
            #1;
            n_cmp++; if (illegal !== 1'b0 || state_dbg !== 3'd0) begin n_err++;
                $display("FAIL ill%0d_clear ill=%b st=%0d want 0 0", k, illegal, state_dbg); end
            tick;
            RST = 1'b1;
            #1;
        end
    endtask

    initial begin
        test_reset;
        test_r_type;
        test_lw_wait;
        test_branch;
        test_store_jal;
        test_illegal;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout compared=%0d", n_cmp);
        $fatal(1);
    end

endmodule
